// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX pipeline register and operand-select stage in front of the ALU.
//   One decoded instruction is captured per accepted handshake. Its operands
//   are resolved at capture time (regfile, immediate, or forwarded from
//   EX/MEM or MEM/WB) and held in registers that drive the ALU next cycle.
//   A load in EX/MEM whose destination feeds this instruction stalls decode
//   and inserts a bubble. A synchronous flush kills both the held and the
//   incoming instruction.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its payload
// stable until the transfer. in_ready is combinational and never depends on
// in_valid. out_valid/payload are registered and stay bit-exact while
// out_ready is low.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   flush                              kill held + incoming instruction
//   in_valid/in_ready                  decode-side handshake
//   in_rs1_addr..in_reg_write          decoded instruction fields
//   exm_rd/exm_reg_write/exm_is_load/exm_result   EX/MEM forwarding source
//   wb_rd/wb_reg_write/wb_data         MEM/WB forwarding source
//   out_valid/out_ready                ALU-side handshake
//   operand1, operand2, func3, subsra  registered ALU controls
//   out_rd, out_reg_write              destination passthrough
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_func3,
  input  logic                  in_funct7b5,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic                  exm_is_load,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand1,
  output logic [XLEN-1:0]       operand2,
  output logic [2:0]            func3,
  output logic                  subsra,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write
);

  // x0 is hardwired zero, so a writer targeting it is never a source.
  logic exm_live, wb_live;
  assign exm_live = exm_reg_write & (exm_rd != '0);
  assign wb_live  = wb_reg_write  & (wb_rd  != '0);

  // Load-use hazard: the load result is not available until next cycle.
  // rs2 only matters when the instruction actually reads it.
  logic hazard;
  assign hazard = exm_is_load & exm_live &
                  ((exm_rd == in_rs1_addr) | (!in_use_imm & (exm_rd == in_rs2_addr)));

  assign in_ready = (!out_valid | out_ready) & !hazard;

  logic capture;
  assign capture = in_valid & in_ready & !flush;

  // Forwarding: EX/MEM is the younger producer, so it wins over MEM/WB.
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  assign rs1_fwd = (exm_live & (exm_rd == in_rs1_addr)) ? exm_result :
                   (wb_live  & (wb_rd  == in_rs1_addr)) ? wb_data    : in_rs1_data;
  assign rs2_fwd = (exm_live & (exm_rd == in_rs2_addr)) ? exm_result :
                   (wb_live  & (wb_rd  == in_rs2_addr)) ? wb_data    : in_rs2_data;

  logic [XLEN-1:0] op2_next;
  assign op2_next = in_use_imm ? in_imm : rs2_fwd;

  // For I-type, bit 30 is part of the immediate: only SRAI (funct3=101 with
  // imm[10] set) selects the arithmetic variant; ADDI never subtracts.
  logic subsra_next;
  assign subsra_next = in_use_imm ? ((in_func3 == 3'b101) & in_imm[10]) : in_funct7b5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      operand1      <= '0;
      operand2      <= '0;
      func3         <= 3'b000;
      subsra        <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      operand1      <= rs1_fwd;
      operand2      <= op2_next;
      func3         <= in_func3;
      subsra        <= subsra_next;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
    end else if (out_ready) begin
      // Slot drained (or bubble): data outputs keep their last value.
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end
  end

endmodule
